// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding, slice sizing
// helpers and the 1-bit full-adder cell used to build each carry slice.
package pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal split: at least one stage, no more stages than bits, equal-sized slices.
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/pipe_addsub_slice.sv
// add_slice: W-bit ripple adder built from full-adder cells; also exposes the carry
// into its MSB so the last slice can form the signed-overflow flag.
module add_slice
  import pipe_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so the ripple reads the carry just computed and no latch is inferred.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
    end
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: WIDTH-bit add/sub with the carry chain cut into STAGES registered
// slices, valid/ready on both sides, one result per cycle with full backpressure.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE = slice_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!split_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipe_addsub: WIDTH must be a positive multiple of STAGES");
  end

  logic [STAGES-1:0] valid_q, valid_d, adv;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d, zero_q, zero_d;

  // What each stage would load: stage 0 from the ports, stage k from stage k-1.
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [STAGES-1:0] src_c, src_v;

  logic [SLICE-1:0]  slc_s  [STAGES];
  logic              slc_co [STAGES];
  logic              cmsb_last;

  always_comb begin
    adv       = '0;
    adv[LAST] = ~valid_q[LAST] | out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = ~valid_q[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  always_comb begin
    src_a[0]   = a;
    src_b[0]   = (sub == OP_SUB) ? ~b : b;
    src_c[0]   = (sub == OP_SUB) ? 1'b1 : cin;
    src_sum[0] = '0;
    src_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = c_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_v[k]   = valid_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic slice_cmsb;

    add_slice #(.W(SLICE)) u_slice (
      .a    (src_a[k][k*SLICE +: SLICE]),
      .b    (src_b[k][k*SLICE +: SLICE]),
      .cin  (src_c[k]),
      .s    (slc_s[k]),
      .cout (slc_co[k]),
      .c_msb(slice_cmsb)
    );

    if (k == LAST) begin : g_last
      assign cmsb_last = slice_cmsb;
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = slice_cmsb;
    end
  end

  // Data only moves with a valid beat, so a stalled or drained output holds its value.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = adv[k] ? src_v[k] : valid_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      sum_d[k]   = sum_q[k];
      c_d[k]     = c_q[k];
      if (adv[k] && src_v[k]) begin
        a_d[k]                     = src_a[k];
        b_d[k]                     = src_b[k];
        sum_d[k]                   = src_sum[k];
        sum_d[k][k*SLICE +: SLICE] = slc_s[k];
        c_d[k]                     = slc_co[k];
      end
    end
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (adv[LAST] && src_v[LAST]) begin
      ovf_d  = cmsb_last ^ slc_co[LAST];
      zero_d = ~|sum_d[LAST];
    end
  end

  // NOTE: state updates use non-blocking '<='. Data registers are cleared on reset
  // too: the last stage drives s/cout directly and those must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // The last stage has no upper operand bits left to forward.
  logic unused_last;
  assign unused_last = ^{a_q[LAST], b_q[LAST]};

  assign out_valid = valid_q[LAST];
  assign s         = sum_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor; successor to the flat 32-bit ripple-carry adder.
- Splits the carry chain into STAGES equal slices, one per clock, with registered carries between slices.
- Valid/ready handshake on both sides, full backpressure, one result per cycle at steady state.
- Serves as the ALU add/sub path and as the accumulate datapath for the sequential multiplier.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices (1..WIDTH); each slice adds SLICE = WIDTH/STAGES bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; add mode only.
- sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of the MSB; in sub mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

Behaviour:
- Reset (async, rst_n low): all stage valid bits 0, so out_valid = 0 and in_ready = 1. s, cout, ovf and zero are 0. Data registers are don't-care.
- Transfer rule: a beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Pipeline structure:
  - STAGES register stages, each with a valid bit.
  - Stage k advances when its own valid is 0 or stage k+1 advances. The last stage advances when out_valid is 0 or out_ready is 1.
  - in_ready = stage 0 may advance (combinational from out_ready through the valid chain; no other combinational input-to-output path).
- Operand preprocessing at accept:
  - Effective B = sub ? ~b : b.
  - Effective carry = sub ? 1 : cin.
- Slice processing:
  - Stage k adds bits [k*SLICE +: SLICE] of A and effective B, plus the carry registered by stage k-1 (stage 0 uses the effective carry).
  - Upper unprocessed operand bits and lower finished sum bits are carried forward in skew registers.
- Latency: exactly STAGES cycles from accept to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Flag computation, in the last stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - zero = ~|s.
- Outputs are registered. Under out_valid & ~out_ready, s/cout/ovf/zero hold stable until consumed.
- Backpressure: with out_ready low, the pipe fills to STAGES beats, then in_ready drops. No beat is dropped or duplicated. Ordering is strictly FIFO.
- Simultaneous consume and accept on a full pipe: permitted in the same cycle (bubble-free).
- STAGES = 1: degenerates to one registered adder, latency 1.
- Wrap-around: arithmetic is modulo 2^WIDTH; all flags are defined as above.
- Reset mid-operation: all in-flight beats are discarded immediately. out_valid goes low asynchronously; no partial result is emitted after release.
- Inputs are sampled only on accept. a/b/sub/cin may change freely otherwise.

Decomposition:
- Shared package holds:
  - localparam helper SLICE = WIDTH/STAGES.
  - An elaboration-time check that WIDTH % STAGES == 0.
  - Op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1.
- One sub-module, add_slice (SLICE-bit ripple adder built from the existing 1-bit adder cells, with carry-in, carry-out and MSB carry-in outputs). Instantiate it STAGES times via generate.

Test Plan (WIDTH=32, STAGES=4):
- Basic add: a=0x0000_0001, b=0x0000_0001, cin=0, sub=0, out_ready=1 -> s=0x0000_0002, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
- Full carry ripple across all slices: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> s=0x0000_0000, cout=1, ovf=0, zero=1.
- Subtract and signed overflow:
  - a=0x8000_0000, b=0x0000_0001, sub=1 -> s=0x7FFF_FFFF, cout=1, ovf=1.
  - a=0x0000_0003, b=0x0000_0005, sub=1 -> s=0xFFFF_FFFE, cout=0, ovf=0.
- Backpressure: stream 6 beats (a=i, b=i, i=1..6) with out_ready=0 -> in_ready falls after 4 accepts. Raise out_ready -> results 2,4,6,8,10,12 in order, no gaps once streaming.
- Reset mid-flight: accept 3 beats, assert rst_n=0 for 1 cycle before any output -> out_valid=0 immediately, in_ready=1 after release, no stale results appear.
- STAGES=1, WIDTH=8 build: a=0x7F, b=0x01 -> s=0x80, ovf=1, latency 1 cycle.
